// File: rtl/irq_reg_bridge.sv
// BAR register bridge to the interrupt controller: MASK/TYPE registers, write-strobe pulses, 2-stage read pipe.
// Optional statistics counters at 0x05/0x06 are built when IRQ_REG_STAT_EN is defined.
module irq_reg_bridge #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_reg_wr_en,
  input  logic [ADDR_W-1:0] i_reg_wr_addr,
  input  logic [31:0]       i_reg_wr_data,
  input  logic              i_reg_rd_req,
  input  logic [ADDR_W-1:0] i_reg_rd_addr,
  output logic [31:0]       o_reg_rd_data,
  output logic              o_reg_rd_vld,
  input  logic [31:0]       i_interrupt_type_reg,
  output logic [31:0]       o_interrupt_mask_reg,
  output logic              o_cpu_rd_interrupt_type_en,
  output logic              o_cpu_enable_mask_en,
  output logic [31:0]       o_cpu_enable_mask_bit,
  output logic              o_cpu_release_mask_en,
  output logic [31:0]       o_cpu_release_mask_bit,
  output logic              o_cpu_interrupt_ack
);

  localparam logic [ADDR_W-1:0] A_MASK    = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_TYPE    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_EN_MASK = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_REL     = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_ACK     = ADDR_W'(4);
`ifdef IRQ_REG_STAT_EN
  localparam logic [ADDR_W-1:0] A_TYPE_CNT = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] A_EN_CNT   = ADDR_W'(6);
`endif

  logic              w_wr_mask, w_wr_en_mask, w_wr_rel, w_wr_ack;
  logic [31:0]       r_mask;
  logic              r_en_pulse, r_rel_pulse, r_ack_pulse;
  logic [31:0]       r_en_bit, r_rel_bit;
  logic [1:0]        r_vld_pipe;
  logic [ADDR_W-1:0] r_s1_addr;
  logic [31:0]       r_rd_data;
  logic [31:0]       w_s1_data;
  logic              w_type_rd;

  assign w_wr_mask    = i_reg_wr_en && (i_reg_wr_addr == A_MASK);
  assign w_wr_en_mask = i_reg_wr_en && (i_reg_wr_addr == A_EN_MASK);
  assign w_wr_rel     = i_reg_wr_en && (i_reg_wr_addr == A_REL);
  assign w_wr_ack     = i_reg_wr_en && (i_reg_wr_addr == A_ACK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask      <= 32'h0000_001F;
      r_en_pulse  <= 1'b0;
      r_rel_pulse <= 1'b0;
      r_ack_pulse <= 1'b0;
      r_en_bit    <= '0;
      r_rel_bit   <= '0;
    end else begin
      if (w_wr_mask) r_mask <= i_reg_wr_data;
      // Pulses re-arm every cycle, so back-to-back writes give back-to-back pulses.
      r_en_pulse  <= w_wr_en_mask;
      r_rel_pulse <= w_wr_rel;
      r_ack_pulse <= w_wr_ack;
      if (w_wr_en_mask) r_en_bit  <= i_reg_wr_data;
      if (w_wr_rel)     r_rel_bit <= i_reg_wr_data;
    end
  end

  // Read stage 1 is the cycle after the request; stage 2 presents data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_s1_addr  <= '0;
      r_rd_data  <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[0], i_reg_rd_req};
      if (i_reg_rd_req)  r_s1_addr <= i_reg_rd_addr;
      if (r_vld_pipe[0]) r_rd_data <= w_s1_data;
    end
  end

  assign w_type_rd = r_vld_pipe[0] && (r_s1_addr == A_TYPE);

`ifdef IRQ_REG_STAT_EN
  logic [31:0] r_type_cnt, r_en_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_type_cnt <= '0;
      r_en_cnt   <= '0;
    end else begin
      if (w_type_rd  && (r_type_cnt != 32'hFFFF_FFFF)) r_type_cnt <= r_type_cnt + 32'd1;
      if (r_en_pulse && (r_en_cnt   != 32'hFFFF_FFFF)) r_en_cnt   <= r_en_cnt + 32'd1;
    end
  end
`endif

  always_comb begin
    w_s1_data = 32'h0;
    case (r_s1_addr)
      // A MASK write landing in the stage-1 cycle is forwarded.
      A_MASK:     w_s1_data = w_wr_mask ? i_reg_wr_data : r_mask;
      A_TYPE:     w_s1_data = i_interrupt_type_reg;
`ifdef IRQ_REG_STAT_EN
      A_TYPE_CNT: w_s1_data = r_type_cnt;
      A_EN_CNT:   w_s1_data = r_en_cnt;
`endif
      default:    w_s1_data = 32'h0;
    endcase
  end

  assign o_reg_rd_data              = r_rd_data;
  assign o_reg_rd_vld               = r_vld_pipe[1];
  assign o_interrupt_mask_reg       = r_mask;
  assign o_cpu_rd_interrupt_type_en = w_type_rd;
  assign o_cpu_enable_mask_en       = r_en_pulse;
  assign o_cpu_enable_mask_bit      = r_en_bit;
  assign o_cpu_release_mask_en      = r_rel_pulse;
  assign o_cpu_release_mask_bit     = r_rel_bit;
  assign o_cpu_interrupt_ack        = r_ack_pulse;

endmodule

// File: tb/tb_irq_reg_bridge.sv
// Directed bench for irq_reg_bridge; stats checks follow IRQ_REG_STAT_EN.
module tb_irq_reg_bridge;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_reg_wr_en;
  logic [ADDR_W-1:0] i_reg_wr_addr;
  logic [31:0]       i_reg_wr_data;
  logic              i_reg_rd_req;
  logic [ADDR_W-1:0] i_reg_rd_addr;
  logic [31:0]       o_reg_rd_data;
  logic              o_reg_rd_vld;
  logic [31:0]       i_interrupt_type_reg;
  logic [31:0]       o_interrupt_mask_reg;
  logic              o_cpu_rd_interrupt_type_en;
  logic              o_cpu_enable_mask_en;
  logic [31:0]       o_cpu_enable_mask_bit;
  logic              o_cpu_release_mask_en;
  logic [31:0]       o_cpu_release_mask_bit;
  logic              o_cpu_interrupt_ack;

  int n_chk = 0;
  int n_err = 0;

  irq_reg_bridge #(.ADDR_W(ADDR_W)) dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .i_reg_wr_en                (i_reg_wr_en),
    .i_reg_wr_addr              (i_reg_wr_addr),
    .i_reg_wr_data              (i_reg_wr_data),
    .i_reg_rd_req               (i_reg_rd_req),
    .i_reg_rd_addr              (i_reg_rd_addr),
    .o_reg_rd_data              (o_reg_rd_data),
    .o_reg_rd_vld               (o_reg_rd_vld),
    .i_interrupt_type_reg       (i_interrupt_type_reg),
    .o_interrupt_mask_reg       (o_interrupt_mask_reg),
    .o_cpu_rd_interrupt_type_en (o_cpu_rd_interrupt_type_en),
    .o_cpu_enable_mask_en       (o_cpu_enable_mask_en),
    .o_cpu_enable_mask_bit      (o_cpu_enable_mask_bit),
    .o_cpu_release_mask_en      (o_cpu_release_mask_en),
    .o_cpu_release_mask_bit     (o_cpu_release_mask_bit),
    .o_cpu_interrupt_ack        (o_cpu_interrupt_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    i_reg_wr_en = 1'b1; i_reg_wr_addr = a; i_reg_wr_data = d;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a);
    i_reg_rd_req = 1'b1; i_reg_rd_addr = a;
  endtask

  task automatic idle();
    i_reg_wr_en = 1'b0; i_reg_rd_req = 1'b0;
  endtask

  task automatic single_read(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] exp);
    rd(a); tick(); idle();
    chk({tag, "_vld_s1"}, 32'(o_reg_rd_vld), 32'd0);
    tick();
    chk({tag, "_vld"}, 32'(o_reg_rd_vld), 32'd1);
    chk({tag, "_data"}, o_reg_rd_data, exp);
  endtask

  initial begin
    rst_n = 1'b0; i_reg_wr_en = 1'b0; i_reg_wr_addr = '0; i_reg_wr_data = '0;
    i_reg_rd_req = 1'b0; i_reg_rd_addr = '0; i_interrupt_type_reg = 32'h0000_0004;
    tick(); tick();
    chk("rst_mask", o_interrupt_mask_reg, 32'h1F);
    chk("rst_vld", 32'(o_reg_rd_vld), 32'd0);
    chk("rst_data", o_reg_rd_data, 32'd0);
    chk("rst_pulses", {27'd0, o_cpu_rd_interrupt_type_en, o_cpu_enable_mask_en,
        o_cpu_release_mask_en, o_cpu_interrupt_ack, 1'b0}, 32'd0);
    chk("rst_en_bit", o_cpu_enable_mask_bit, 32'd0);
    chk("rst_rel_bit", o_cpu_release_mask_bit, 32'd0);
    rst_n = 1'b1;
    tick();

    single_read("rd_mask_rst", 8'h00, 32'h1F);
    tick();
    chk("vld_drop", 32'(o_reg_rd_vld), 32'd0);
    chk("data_hold", o_reg_rd_data, 32'h1F);

    // Strobe registers
    wr(8'h02, 32'h12); tick(); idle();
    chk("en_pulse", 32'(o_cpu_enable_mask_en), 32'd1);
    chk("en_bit", o_cpu_enable_mask_bit, 32'h12);
    chk("en_no_rel", 32'(o_cpu_release_mask_en), 32'd0);
    tick();
    chk("en_pulse_end", 32'(o_cpu_enable_mask_en), 32'd0);
    chk("en_bit_hold", o_cpu_enable_mask_bit, 32'h12);
    wr(8'h03, 32'hA5); tick(); idle();
    chk("rel_pulse", 32'(o_cpu_release_mask_en), 32'd1);
    chk("rel_bit", o_cpu_release_mask_bit, 32'hA5);
    tick();
    chk("rel_pulse_end", 32'(o_cpu_release_mask_en), 32'd0);
    wr(8'h04, 32'hDEAD); tick(); idle();
    chk("ack_pulse", 32'(o_cpu_interrupt_ack), 32'd1);
    tick();
    chk("ack_pulse_end", 32'(o_cpu_interrupt_ack), 32'd0);

    // Back-to-back enable writes
    wr(8'h02, 32'h1); tick(); wr(8'h02, 32'h2);
    chk("b2b_p1", 32'(o_cpu_enable_mask_en), 32'd1);
    chk("b2b_b1", o_cpu_enable_mask_bit, 32'h1);
    tick(); idle();
    chk("b2b_p2", 32'(o_cpu_enable_mask_en), 32'd1);
    chk("b2b_b2", o_cpu_enable_mask_bit, 32'h2);
    tick();
    chk("b2b_end", 32'(o_cpu_enable_mask_en), 32'd0);

    // Discarded writes
    wr(8'h01, 32'hFFFF_FFFF); tick(); wr(8'h07, 32'hFFFF_FFFF); tick(); idle();
    chk("disc_mask", o_interrupt_mask_reg, 32'h1F);
    chk("disc_pulses", {29'd0, o_cpu_enable_mask_en, o_cpu_release_mask_en, o_cpu_interrupt_ack}, 32'd0);
    tick();

    // TYPE read
    rd(8'h01); tick(); idle();
    chk("type_en", 32'(o_cpu_rd_interrupt_type_en), 32'd1);
    chk("type_vld_s1", 32'(o_reg_rd_vld), 32'd0);
    tick();
    chk("type_en_end", 32'(o_cpu_rd_interrupt_type_en), 32'd0);
    chk("type_vld", 32'(o_reg_rd_vld), 32'd1);
    chk("type_data", o_reg_rd_data, 32'h4);

    // Pipelined reads 0x00, 0x01, 0x07
    rd(8'h00); tick(); rd(8'h01); tick(); rd(8'h07);
    chk("pipe0_vld", 32'(o_reg_rd_vld), 32'd1);
    chk("pipe0_data", o_reg_rd_data, 32'h1F);
    tick(); idle();
    chk("pipe1_vld", 32'(o_reg_rd_vld), 32'd1);
    chk("pipe1_data", o_reg_rd_data, 32'h4);
    tick();
    chk("pipe2_vld", 32'(o_reg_rd_vld), 32'd1);
    chk("pipe2_data", o_reg_rd_data, 32'h0);
    tick();
    chk("pipe_end", 32'(o_reg_rd_vld), 32'd0);

    // Write and read MASK in the same cycle
    wr(8'h00, 32'h3); rd(8'h00); tick(); idle();
    chk("wr_rd_mask", o_interrupt_mask_reg, 32'h3);
    tick();
    chk("wr_rd_vld", 32'(o_reg_rd_vld), 32'd1);
    chk("wr_rd_data", o_reg_rd_data, 32'h3);

    // MASK write coinciding with read stage 1 is forwarded
    rd(8'h00); tick(); idle(); wr(8'h00, 32'h7); tick(); idle();
    chk("fwd_vld", 32'(o_reg_rd_vld), 32'd1);
    chk("fwd_data", o_reg_rd_data, 32'h7);
    single_read("rd_wo", 8'h02, 32'h0);

    // Reset during an in-flight TYPE read
    rd(8'h01); tick(); idle();
    rst_n = 1'b0; #1;
    chk("rstmid_type_en", 32'(o_cpu_rd_interrupt_type_en), 32'd0);
    chk("rstmid_mask", o_interrupt_mask_reg, 32'h1F);
    tick(); rst_n = 1'b1;
    tick();
    chk("rstrel_vld_a", 32'(o_reg_rd_vld), 32'd0);
    chk("rstrel_type_a", 32'(o_cpu_rd_interrupt_type_en), 32'd0);
    tick();
    chk("rstrel_vld_b", 32'(o_reg_rd_vld), 32'd0);

    // Stats counters, freshly cleared by the reset above
    wr(8'h02, 32'h9); tick(); idle(); tick();
    rd(8'h01); tick(); rd(8'h01); tick(); rd(8'h01); tick(); idle(); tick(); tick();
`ifdef IRQ_REG_STAT_EN
    single_read("cnt_type", 8'h05, 32'd3);
    single_read("cnt_en", 8'h06, 32'd1);
`else
    single_read("cnt_type", 8'h05, 32'd0);
    single_read("cnt_en", 8'h06, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/irq_reg_bridge.md
IRQ_REG_BRIDGE -- requirements
Module: irq_reg_bridge

Interface
REQ-001 Parameter: ADDR_W, default 8, register dword-offset width.
REQ-002 clk  in  1  sole clock; all logic rising-edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 i_reg_wr_en  in  1  single-cycle BAR register write strobe.
REQ-005 i_reg_wr_addr  in  ADDR_W  write dword offset.
REQ-006 i_reg_wr_data  in  32  write data.
REQ-007 i_reg_rd_req  in  1  single-cycle read request; one may arrive every cycle.
REQ-008 i_reg_rd_addr  in  ADDR_W  read dword offset.
REQ-009 o_reg_rd_data  out  32  read data, valid with o_reg_rd_vld.
REQ-010 o_reg_rd_vld  out  1  read-data valid pulse.
REQ-011 i_interrupt_type_reg  in  32  latched interrupt type from the interrupt controller.
REQ-012 o_interrupt_mask_reg  out  32  interrupt mask to the controller.
REQ-013 o_cpu_rd_interrupt_type_en  out  1  type-register-read pulse.
REQ-014 o_cpu_enable_mask_en / o_cpu_enable_mask_bit  out  1/32  enable-mask write pulse plus data.
REQ-015 o_cpu_release_mask_en / o_cpu_release_mask_bit  out  1/32  release-mask write pulse plus data.
REQ-016 o_cpu_interrupt_ack  out  1  interrupt-ack write pulse.

Function
REQ-017 Register map: 0x00 MASK (RW); 0x01 TYPE (RO); 0x02 ENABLE_MASK (WO); 0x03 RELEASE_MASK (WO); 0x04 ACK (WO); 0x05 TYPE_RD_CNT (RO, stats); 0x06 EN_MASK_CNT (RO, stats).
REQ-018 A MASK write updates o_interrupt_mask_reg on the next clock edge.
REQ-019 An ENABLE_MASK write drives o_cpu_enable_mask_en high for exactly 1 cycle, starting 1 cycle after i_reg_wr_en, with o_cpu_enable_mask_bit = write data in that cycle.
REQ-020 RELEASE_MASK writes behave the same way on the release outputs; ACK writes give a 1-cycle o_cpu_interrupt_ack pulse 1 cycle after the write, ignoring the data.
REQ-021 The *_mask_bit outputs hold their last written value between pulses.
REQ-022 Back-to-back writes to the same strobe register produce back-to-back pulses, with no merging or loss.
REQ-023 Writes to TYPE, the counters, or unmapped offsets are discarded and have no side effect.
REQ-024 Reads use a 2-stage pipeline: the request is registered at stage 1 with the address decoded and data selected; o_reg_rd_vld is asserted 2 cycles after i_reg_rd_req.
REQ-025 A TYPE read samples i_interrupt_type_reg in the stage-1 cycle; o_cpu_rd_interrupt_type_en pulses in that same cycle, 1 cycle after the request.
REQ-026 Read data for MASK is the current register value, or the value written in the same cycle if a write to MASK coincides with stage 1.
REQ-027 Read data for WO and unmapped offsets is 0x00000000.
REQ-028 Simultaneous read and write in the same cycle are both serviced independently.
REQ-029 Pipelined reads accepted every cycle return in request order, one o_reg_rd_vld per request.
REQ-030 o_reg_rd_data holds its last value when o_reg_rd_vld is low.

Reset
REQ-031 When rst_n is low: o_interrupt_mask_reg = 0x0000001F; all pulses, o_reg_rd_vld, the mask_bit outputs, o_reg_rd_data, the counters and the pipeline are cleared to 0.
REQ-032 Reset asserted mid-read drops the in-flight request: no o_reg_rd_vld and no type-read pulse after reset is released.

Configuration
REQ-033 Macro IRQ_REG_STAT_EN defined: TYPE_RD_CNT counts o_cpu_rd_interrupt_type_en pulses, EN_MASK_CNT counts o_cpu_enable_mask_en pulses; both are 32-bit, saturate at 0xFFFFFFFF and are readable at 0x05/0x06.
REQ-034 Macro IRQ_REG_STAT_EN undefined: no counter logic is present; 0x05/0x06 read 0x00000000.

Verification
REQ-035 Release reset, then read 0x00 -> o_reg_rd_vld 2 cycles later with data 0x0000001F.
REQ-036 Write 0x02 with 0x00000012 -> o_cpu_enable_mask_en high for 1 cycle at write+1 with o_cpu_enable_mask_bit = 0x00000012; writes to 0x03 and 0x04 give the equivalent single pulses.
REQ-037 Hold i_interrupt_type_reg = 0x00000004 and read 0x01 -> o_cpu_rd_interrupt_type_en at req+1, vld at req+2 with data 0x00000004.
REQ-038 Reads of 0x00, 0x01, 0x07 on 3 consecutive cycles -> 3 consecutive vld cycles returning 0x1F, the type value, and 0x0.
REQ-039 Write MASK = 0x3 and read MASK in the same cycle -> read returns 0x3; o_interrupt_mask_reg = 0x3 next cycle.
REQ-040 Stats build: 3 TYPE reads, then read 0x05 -> 0x00000003; drop rst_n during a pending read -> no vld after release.
